// File: rtl/multi_wave_osc.sv
// Phase-accumulator oscillator producing saw-up, saw-down, triangle or square
// samples through a valid/ready output stage.
module multi_wave_osc #(
  parameter int width_p       = 12,
  parameter int phase_width_p = 24
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     en_i,
  input  logic [phase_width_p-1:0] freq_i,
  input  logic [1:0]               mode_i,
  input  logic                     sync_i,
  input  logic                     ready_i,
  output logic [width_p-1:0]       data_o,
  output logic                     valid_o,
  output logic                     wrap_o
);

  localparam int W = width_p;
  localparam int P = phase_width_p;
  localparam logic [W-1:0] LP_H = {1'b1, {(W-1){1'b0}}};

  // Handshake: data_o/wrap_o are offered while valid_o=1 and are consumed on a
  // rising edge where ready_i=1; while valid_o=1 and ready_i=0 all outputs and
  // the phase hold. A new sample is produced whenever en_i=1 and the output
  // register is empty or being consumed in the same cycle.
  logic [P-1:0] r_ph;
  logic [W-1:0] r_data;
  logic         r_valid;
  logic         r_wrap;

  logic         w_adv;
  logic [P-1:0] w_ph_used;
  logic [P:0]   w_sum;
  logic [W-1:0] w_p;
  logic [W-1:0] w_q;
  logic         w_m;
  logic [W-1:0] w_saw_up;
  logic [W-1:0] w_wave;

  assign w_adv     = en_i & (~r_valid | ready_i);
  assign w_ph_used = sync_i ? '0 : r_ph;
  assign w_sum     = {1'b0, w_ph_used} + {1'b0, freq_i};

  assign w_p      = w_ph_used[P-1 -: W];
  assign w_q      = w_ph_used[P-2 -: W];
  assign w_m      = w_ph_used[P-1];
  assign w_saw_up = w_p - LP_H;

  always_comb begin
    w_wave = '0;
    case (mode_i)
      2'd0:    w_wave = w_saw_up;
      2'd1:    w_wave = ~w_saw_up;
      2'd2:    w_wave = (w_m ? ~w_q : w_q) - LP_H;
      default: w_wave = w_m ? LP_H : ~LP_H;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_ph    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_adv) begin
      r_data  <= w_wave;
      r_ph    <= w_sum[P-1:0];
      r_wrap  <= w_sum[P];
      r_valid <= 1'b1;
    end else begin
      // A restart request still zeroes the phase even when no sample goes out.
      if (sync_i) r_ph <= '0;
      if (r_valid && ready_i) r_valid <= 1'b0;
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign wrap_o  = r_wrap;

endmodule

// File: tb/tb_multi_wave_osc.sv
// Bench for multi_wave_osc: fixed vectors for the documented sequences, hand
// sequences for stall/sync/enable/reset corners, and a randomized model run.
module tb_multi_wave_osc;

  localparam int W = 12;
  localparam int P = 24;

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic          en_i = 1'b0;
  logic [P-1:0]  freq_i = '0;
  logic [1:0]    mode_i = 2'd0;
  logic          sync_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [W-1:0]  data_o;
  logic          valid_o;
  logic          wrap_o;

  multi_wave_osc #(.width_p(W), .phase_width_p(P)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .en_i(en_i), .freq_i(freq_i),
    .mode_i(mode_i), .sync_i(sync_i), .ready_i(ready_i),
    .data_o(data_o), .valid_o(valid_o), .wrap_o(wrap_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural reference: phase as a plain integer, waveforms by arithmetic.
  longint m_ph = 0;
  int     m_data = 0;
  bit     m_valid = 0;
  bit     m_wrap = 0;

  function automatic int wave(longint ph, int mode);
    int p, q, m, v;
    p = int'(ph / 4096);
    q = int'((ph / 2048) % 4096);
    m = int'(ph / (1 << 23));
    case (mode)
      0:       v = p - 2048;
      1:       v = -(p - 2048) - 1;
      2:       v = (m != 0 ? 4095 - q : q) - 2048;
      default: v = (m != 0) ? -2048 : 2047;
    endcase
    return v;
  endfunction

  task automatic model_step();
    bit     adv;
    longint used, sum;
    adv  = en_i && (!m_valid || ready_i);
    used = sync_i ? 0 : m_ph;
    if (adv) begin
      m_data  = wave(used, int'(mode_i));
      sum     = used + longint'(freq_i);
      m_wrap  = (sum >= (longint'(1) << P));
      m_ph    = sum % (longint'(1) << P);
      m_valid = 1;
    end else begin
      if (sync_i) m_ph = 0;
      if (m_valid && ready_i) m_valid = 0;
    end
  endtask

  task automatic check(string name, int e_data, bit e_valid, bit e_wrap);
    logic [W-1:0] ed;
    ed = e_data[W-1:0];
    n_vec++;
    if (data_o !== ed || valid_o !== e_valid || wrap_o !== e_wrap) begin
      n_err++;
      $display("FAIL %s: got data=%0d valid=%b wrap=%b, want data=%0d valid=%b wrap=%b",
               name, $signed(data_o), valid_o, wrap_o, $signed(ed), e_valid, e_wrap);
    end
  endtask

  task automatic check_model(string name);
    check(name, m_data, m_valid, m_wrap);
  endtask

  task automatic step();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    m_ph = 0; m_data = 0; m_valid = 0; m_wrap = 0;
    #1;
    check("reset", 0, 0, 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  task automatic drive(bit en, bit rdy, bit syn, logic [1:0] mode, logic [P-1:0] freq);
    en_i = en; ready_i = rdy; sync_i = syn; mode_i = mode; freq_i = freq;
  endtask

  typedef struct {
    bit           rst;
    bit           en;
    bit           ready;
    bit           sync;
    logic [1:0]   mode;
    logic [P-1:0] freq;
    int           exp_data;
    bit           exp_valid;
    bit           exp_wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit en, logic [1:0] mode, logic [P-1:0] freq,
                              int d, bit v, bit w);
    vec_t t;
    t.rst = rst; t.en = en; t.ready = 1'b1; t.sync = 1'b0; t.mode = mode; t.freq = freq;
    t.exp_data = d; t.exp_valid = v; t.exp_wrap = w;
    return t;
  endfunction

  initial begin
    // Saw-up ramp: 16 steps of 256, wrap flagged with the last, then restart.
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(i == 0, 1, 2'd0, 24'h100000, -2048 + 256 * i, 1, i == 15));
    vecs.push_back(mk(0, 1, 2'd0, 24'h100000, -2048, 1, 0));
    // Triangle, quarter-cycle steps; the descending half uses ~q.
    vecs.push_back(mk(1, 1, 2'd2, 24'h400000, -2048, 1, 0));
    vecs.push_back(mk(0, 1, 2'd2, 24'h400000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 2'd2, 24'h400000, 2047, 1, 0));
    vecs.push_back(mk(0, 1, 2'd2, 24'h400000, -1, 1, 1));
    vecs.push_back(mk(0, 1, 2'd2, 24'h400000, -2048, 1, 0));
    // Square, quarter-cycle steps.
    vecs.push_back(mk(1, 1, 2'd3, 24'h400000, 2047, 1, 0));
    vecs.push_back(mk(0, 1, 2'd3, 24'h400000, 2047, 1, 0));
    vecs.push_back(mk(0, 1, 2'd3, 24'h400000, -2048, 1, 0));
    vecs.push_back(mk(0, 1, 2'd3, 24'h400000, -2048, 1, 1));
    vecs.push_back(mk(0, 1, 2'd3, 24'h400000, 2047, 1, 0));
    // Idle after reset, then saw-down with zero tuning word: constant output.
    vecs.push_back(mk(1, 0, 2'd1, 24'h000000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2'd1, 24'h000000, 2047, 1, 0));
    vecs.push_back(mk(0, 1, 2'd1, 24'h000000, 2047, 1, 0));
    vecs.push_back(mk(0, 1, 2'd1, 24'h000000, 2047, 1, 0));

    #2;
    check("power_on_reset", 0, 0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].en, vecs[i].ready, vecs[i].sync, vecs[i].mode, vecs[i].freq);
      step();
      check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_wrap);
    end

    // Stall for 3 cycles mid-ramp; mode/freq changes during the stall are ignored.
    do_reset();
    drive(1, 1, 0, 2'd0, 24'h100000);
    repeat (4) step();
    check("pre_stall", -1280, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 2'd3, 24'h012345);
      step();
      check($sformatf("stall%0d", i), -1280, 1, 0);
    end
    drive(1, 1, 0, 2'd0, 24'h100000);
    step();
    check("post_stall", -1024, 1, 0);

    // One-cycle phase restart mid-ramp.
    step();
    drive(1, 1, 1, 2'd0, 24'h100000);
    step();
    check("sync_sample", -2048, 1, 0);
    drive(1, 1, 0, 2'd0, 24'h100000);
    step();
    check("sync_next", -1792, 1, 0);

    // Enable drop with ready high: valid clears, phase frozen, then resumes.
    drive(0, 1, 0, 2'd0, 24'h100000);
    step();
    check("en_drop", -1792, 0, 0);
    step();
    check("en_idle", -1792, 0, 0);
    drive(1, 1, 0, 2'd0, 24'h100000);
    step();
    check("en_resume", -1536, 1, 0);

    // Asynchronous reset between edges, then restart with en=1.
    step();
    #2;
    reset_ni = 1'b0;
    m_ph = 0; m_data = 0; m_valid = 0; m_wrap = 0;
    #1;
    check("async_reset", 0, 0, 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    step();
    check("after_reset", -2048, 1, 0);

    // Randomized run against the reference model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)),
            (i % 50 < 25) ? P'($urandom) : P'($urandom_range(0, 1 << 20)));
      step();
      check_model($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
